// File: rtl/mssd_serializer.sv
// mssd_serializer: serialises port/len/data requests into the MSSD frame format
// (start 0, 2-bit port, 4-bit length, N payload bits MSB first, idle-high stop bits).
module mssd_serializer #(
    parameter int STOP_BITS = 1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [1:0]  port,
    input  logic [3:0]  len,
    input  logic [14:0] data,
    output logic        serOut,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_LEN, S_DATA, S_STOP} state_t;
    localparam logic [3:0] STOP_LOAD = 4'(STOP_BITS - 1);
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_len;
    logic [1:0]  r_port;
    logic [14:0] r_data;
    logic        r_ser;
    logic        r_done;
    logic [3:0]  w_cm1;
    logic [3:0]  w_lm1;
    assign w_cm1   = r_cnt - 4'd1;
    assign w_lm1   = r_len - 4'd1;
    assign inReady = r_state == S_IDLE;
    assign busy    = r_state != S_IDLE;
    assign serOut  = r_ser;
    assign done    = r_done;
    // r_cnt holds the index of the bit currently on the line; the next bit is chosen one edge early
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ser   <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_port  <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (inValid) begin
                    r_state <= S_START;
                    r_ser   <= 1'b0;
                    r_port  <= port;
                    r_len   <= len;
                    r_data  <= data;
                end
                S_START: begin
                    r_state <= S_ADDR;
                    r_ser   <= r_port[1];
                    r_cnt   <= 4'd1;
                end
                S_ADDR: if (r_cnt != 4'd0) begin
                    r_ser <= r_port[w_cm1[0]];
                    r_cnt <= w_cm1;
                end else begin
                    r_state <= S_LEN;
                    r_ser   <= r_len[3];
                    r_cnt   <= 4'd3;
                end
                S_LEN: if (r_cnt != 4'd0) begin
                    r_ser <= r_len[w_cm1[1:0]];
                    r_cnt <= w_cm1;
                end else if (r_len != 4'd0) begin
                    r_state <= S_DATA;
                    r_ser   <= r_data[w_lm1];
                    r_cnt   <= w_lm1;
                end else begin
                    r_state <= S_STOP;
                    r_ser   <= 1'b1;
                    r_done  <= 1'b1;
                    r_cnt   <= STOP_LOAD;
                end
                S_DATA: if (r_cnt != 4'd0) begin
                    r_ser <= r_data[w_cm1];
                    r_cnt <= w_cm1;
                end else begin
                    r_state <= S_STOP;
                    r_ser   <= 1'b1;
                    r_done  <= 1'b1;
                    r_cnt   <= STOP_LOAD;
                end
                S_STOP: if (r_cnt != 4'd0) r_cnt <= w_cm1;
                        else r_state <= S_IDLE;
                default: begin
                    r_state <= S_IDLE;
                    r_ser   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mssd_serializer.sv
// tb_mssd_serializer: directed frame table, reset-abort sequence and a back-to-back
// stream decoded by a bench-side MSSD receiver model.
module tb_mssd_serializer;
    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [1:0]  port = '0;
    logic [3:0]  len = '0;
    logic [14:0] data = '0;
    logic        serOut;
    logic        busy;
    logic        done;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  len;
        logic [14:0] data;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[5];
    vec_t rvec;
    vec_t expq[$];
    logic sq[$];

    mssd_serializer #(.STOP_BITS(1)) dut (
        .Clk(Clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .port(port), .len(len), .data(data),
        .serOut(serOut), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, req);
        end
    endtask

    // Sends one request and checks the serial image, done pulse and return to idle.
    task automatic send_check(input vec_t v, input string nm);
        logic [21:0] got;
        logic        done_early;
        int          nb;
        nb = 7 + int'(v.len);
        got = '0;
        done_early = 1'b0;
        @(negedge Clk);
        port = v.port;
        len = v.len;
        data = v.data;
        inValid = 1'b1;
        chk({nm, " ready"}, 32'(inReady), 32'd1);
        @(posedge Clk);
        #1;
        inValid = 1'b0;
        port = ~v.port;
        len = ~v.len;
        data = ~v.data;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) begin
                @(posedge Clk);
                #1;
            end
            got[21-i] = serOut;
            done_early = done_early | done | ~busy;
        end
        chk({nm, " bits"}, 32'(got), 32'(v.exp));
        chk({nm, " done/busy in frame"}, 32'(done_early), 32'd0);
        @(posedge Clk);
        #1;
        chk({nm, " stop"}, {29'd0, serOut, done, busy}, 32'b111);
        @(posedge Clk);
        #1;
        chk({nm, " idle"}, {28'd0, serOut, done, busy, inReady}, 32'b1001);
    endtask

    initial begin
        vecs[0] = '{2'd2, 4'd3,  15'h0005, 22'b0100011101_000000000000};
        vecs[1] = '{2'd3, 4'd0,  15'h1234, 22'b0110000_000000000000000};
        vecs[2] = '{2'd1, 4'd15, 15'h7FFF, 22'b0011111_111111111111111};
        vecs[3] = '{2'd0, 4'd2,  15'h7FFE, 22'b000001010_0000000000000};
        vecs[4] = '{2'd2, 4'd5,  15'h7FF3, 22'b010010110011_0000000000};

        #23;
        chk("reset outputs", {29'd0, serOut, done, busy}, 32'b100);
        @(negedge Clk);
        reset = 1'b1;
        #1;
        chk("ready after reset", 32'(inReady), 32'd1);

        foreach (vecs[k]) send_check(vecs[k], $sformatf("vec%0d", k));

        // Reset during the third payload bit of an 8-bit frame.
        rvec = '{2'd1, 4'd8, 15'h005A, 22'b0011000_010110100000000};
        @(negedge Clk);
        port = rvec.port;
        len = rvec.len;
        data = rvec.data;
        inValid = 1'b1;
        @(posedge Clk);
        #1;
        inValid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge Clk);
            #1;
        end
        chk("pre-reset data bit", {30'd0, serOut, busy}, 32'b01);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset", {29'd0, serOut, done, busy}, 32'b100);
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        send_check(rvec, "post-reset");

        // Continuous requests with inputs changing every cycle; bench tracks acceptance.
        begin
            int rem;
            rem = 0;
            for (int c = 0; c < 430; c++) begin
                @(negedge Clk);
                port = 2'($urandom);
                len = 4'($urandom);
                data = 15'($urandom);
                inValid = c < 400;
                chk("b2b ready", 32'(inReady), 32'(rem == 0));
                if (rem == 0) begin
                    if (inValid) begin
                        expq.push_back('{port, len, data, 22'd0});
                        rem = 8 + int'(len);
                    end
                end else rem--;
                @(posedge Clk);
                #1;
                sq.push_back(serOut);
            end
        end

        // Receiver model: decode the captured line and compare against accepted requests.
        begin
            int i, run, nfr, nexp;
            logic first;
            logic [1:0]  p;
            logic [3:0]  l;
            logic [14:0] d, m;
            vec_t e;
            i = 0;
            run = 0;
            nfr = 0;
            first = 1'b1;
            nexp = expq.size();
            while (i < sq.size()) begin
                if (sq[i]) begin
                    run++;
                    i++;
                end else if (i + 7 > sq.size()) begin
                    chk("rx truncated header", 32'(i), 32'(sq.size()));
                    i = sq.size();
                end else begin
                    p = {sq[i+1], sq[i+2]};
                    l = {sq[i+3], sq[i+4], sq[i+5], sq[i+6]};
                    i += 7;
                    d = '0;
                    for (int k = 0; k < int'(l); k++) begin
                        d = {d[13:0], (i < sq.size()) ? sq[i] : 1'b1};
                        i++;
                    end
                    if (expq.size() == 0) begin
                        chk("rx extra frame", 32'(nfr), 32'(nexp));
                    end else begin
                        e = expq.pop_front();
                        m = 15'((16'd1 << e.len) - 16'd1);
                        chk("rx port", 32'(p), 32'(e.port));
                        chk("rx len", 32'(l), 32'(e.len));
                        chk("rx data", 32'(d), 32'(e.data & m));
                    end
                    if (!first) chk("rx idle gap", 32'(run), 32'd2);
                    first = 1'b0;
                    run = 0;
                    nfr++;
                end
            end
            chk("rx frame count", 32'(nfr), 32'(nexp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
